// File: rtl/i2c_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter_pkg
// Purpose  : Shared state encoding and transaction word layout for the
//            I2C request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_req_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RETRY = 3'd3,
        S_FIN   = 3'd4
    } arb_state_t;

    // Transaction word is {slave addr, sub-addr, data}, one byte each
    localparam int   c_WORD_W = 24;
    localparam int   c_BYTE_W = 8;

    // Engine reports 0 when every byte was acknowledged
    localparam logic c_ACK_OK = 1'b0;

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter_if
// Purpose  : Requester and engine signals of the I2C request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_req_arbiter_if
    import i2c_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    logic                          iSTEP;
    logic [NUM_REQ-1:0]            iREQ;
    logic [NUM_REQ-1:0]            iWR;
    logic [NUM_REQ*c_WORD_W-1:0]   iWDATA;
    logic [NUM_REQ-1:0]            oGNT;
    logic [NUM_REQ-1:0]            oDONE;
    logic [NUM_REQ-1:0]            oERR;
    logic [c_BYTE_W-1:0]           oRDATA;
    logic                          oGO;
    logic                          oWR;
    logic [c_WORD_W-1:0]           oWDATA;
    logic                          iEND;
    logic                          iACK;
    logic [c_BYTE_W-1:0]           iRDATA;

    modport slave (
        input  iSTEP, iREQ, iWR, iWDATA, iEND, iACK, iRDATA,
        output oGNT, oDONE, oERR, oRDATA, oGO, oWR, oWDATA
    );

    modport master (
        output iSTEP, iREQ, iWR, iWDATA, iEND, iACK, iRDATA,
        input  oGNT, oDONE, oERR, oRDATA, oGO, oWR, oWDATA
    );

endinterface
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : i2c_rr_pick
// Purpose  : Combinational round-robin pick: first active request at or
//            after the pointer, as one-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         iREQ,
    input  logic [$clog2(NUM_REQ)-1:0] iPTR,
    output logic [NUM_REQ-1:0]         oGNT,
    output logic [$clog2(NUM_REQ)-1:0] oIDX,
    output logic                       oANY
);
    localparam int c_IDX_W = $clog2(NUM_REQ);

    logic [c_IDX_W-1:0] w_pos;

    // Walk from the farthest position back to the pointer so the last hit wins
    always_comb begin
        oGNT  = '0;
        oIDX  = '0;
        oANY  = 1'b0;
        w_pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = c_IDX_W'((int'(iPTR) + k) % NUM_REQ);
            if (iREQ[w_pos]) begin
                oGNT        = '0;
                oGNT[w_pos] = 1'b1;
                oIDX        = w_pos;
                oANY        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter
// Purpose  : Round-robin arbiter sharing one I2C transaction engine between
//            NUM_REQ requesters, with NACK retry. Define I2C_ARB_TIMEOUT_EN
//            to add the step-count timeout on stuck transactions.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT_STEPS = 1023
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    i2c_req_arbiter_if.slave bus
);
    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_t         r_state;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_RTY_W-1:0] r_retry;
    logic               r_wr;
    logic               r_err;

    logic [NUM_REQ-1:0] w_gnt;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_any;
    logic               w_tmo_hit;

    if ((NUM_REQ < 2) || (NUM_REQ > 4) || (MAX_RETRY < 0) || (TIMEOUT_STEPS < 1)) begin : g_param_err
        $error("i2c_req_arbiter: parameter out of range");
    end

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .iREQ (bus.iREQ),
        .iPTR (r_ptr),
        .oGNT (w_gnt),
        .oIDX (w_idx),
        .oANY (w_any)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_STEPS + 1);

    logic [c_TMO_W-1:0] r_tmo;

    // Restarts from zero on every attempt; retries get a fresh budget
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_tmo <= '0;
        end else if (bus.iSTEP) begin
            if ((r_state == S_IDLE) || (r_state == S_RETRY)) begin
                r_tmo <= '0;
            end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign w_tmo_hit = (r_tmo == c_TMO_W'(TIMEOUT_STEPS - 1)) &&
                       ((r_state == S_ISSUE) || (r_state == S_WAIT));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_wr       <= 1'b0;
            r_err      <= 1'b0;
            bus.oGNT   <= '0;
            bus.oDONE  <= '0;
            bus.oERR   <= '0;
            bus.oRDATA <= '0;
            bus.oGO    <= 1'b0;
            bus.oWR    <= 1'b0;
            bus.oWDATA <= '0;
        end else begin
            bus.oDONE <= '0;
            bus.oERR  <= '0;
            if (bus.iSTEP) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            bus.oGNT   <= w_gnt;
                            r_idx      <= w_idx;
                            r_wr       <= bus.iWR[w_idx];
                            r_err      <= 1'b0;
                            bus.oWDATA <= bus.iWDATA[w_idx*c_WORD_W +: c_WORD_W];
                            bus.oGO    <= 1'b1;
                            bus.oWR    <= bus.iWR[w_idx];
                            r_state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (w_tmo_hit) begin
                            bus.oGO <= 1'b0;
                            bus.oWR <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                        end else if (!bus.iEND) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.iEND) begin
                            bus.oGO <= 1'b0;
                            bus.oWR <= 1'b0;
                            if (bus.iACK == c_ACK_OK) begin
                                bus.oRDATA <= bus.iRDATA;
                                r_state    <= S_FIN;
                            end else if (r_retry < c_RTY_W'(MAX_RETRY)) begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= S_RETRY;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_FIN;
                            end
                        end else if (w_tmo_hit) begin
                            bus.oGO <= 1'b0;
                            bus.oWR <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                    S_RETRY: begin
                        bus.oGO <= 1'b1;
                        bus.oWR <= r_wr;
                        r_state <= S_ISSUE;
                    end
                    S_FIN: begin
                        if (r_err) begin
                            bus.oERR <= bus.oGNT;
                        end else begin
                            bus.oDONE <= bus.oGNT;
                        end
                        bus.oGNT <= '0;
                        r_retry  <= '0;
                        r_ptr    <= (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + 1'b1;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Purpose  : Self-checking bench: cycle vectors for write/read, plus
//            sequences for contention, NACK retry, reset and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    i2c_req_arbiter_if #(.NUM_REQ(2)) bus ();

    i2c_req_arbiter #(
        .NUM_REQ       (2),
        .MAX_RETRY     (3),
        .TIMEOUT_STEPS (8)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        logic        step;
        logic [1:0]  req;
        logic [1:0]  wr;
        logic        iend;
        logic        ack;
        logic [7:0]  rd;
        logic [1:0]  gnt;
        logic        go;
        logic        owr;
        logic [1:0]  done;
        logic [1:0]  err;
        logic [23:0] wdata;
        logic [7:0]  rdata;
    } vec_t;

    vec_t tv[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Engine model: starts when oGO is seen with the engine idle, busy two
    // cycles, NACKs the first 'nacks' attempts.
    task automatic serve(input int nacks, output int gos, output logic [1:0] gnt,
                         output logic [1:0] done, output logic [1:0] err);
        int   busy;
        int   issued;
        logic prev_go;
        logic fin;
        gos = 0; gnt = '0; done = '0; err = '0;
        busy = 0; issued = 0; prev_go = 1'b0; fin = 1'b0;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clk);
            if (bus.oGO && !prev_go) gos++;
            prev_go = bus.oGO;
            if (gnt == 2'b00) gnt = bus.oGNT;
            if ((bus.oDONE != 2'b00) || (bus.oERR != 2'b00)) begin
                done = bus.oDONE;
                err  = bus.oERR;
                fin  = 1'b1;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    bus.iEND = 1'b1;
                    bus.iACK = (issued <= nacks) ? 1'b1 : 1'b0;
                end
            end else if (bus.oGO && bus.iEND) begin
                issued++;
                bus.iEND = 1'b0;
                busy = 2;
            end
        end
        check("serve_bound", {31'd0, fin}, 32'd1);
    endtask

    int         gos;
    logic [1:0] g;
    logic [1:0] d;
    logic [1:0] e;
    int         go_cnt;
    logic [1:0] err_seen;
    logic [1:0] exp_order [4];

    initial begin
        checks = 0;
        errors = 0;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;

        //          step  req    wr     end   ack   rd      gnt    go    owr   done   err    wdata        rdata
        tv[0]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 8'h00,  2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 24'h000000, 8'h00};
        tv[1]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 8'h00,  2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 24'h421280, 8'h00};
        tv[2]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 8'h00,  2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 24'h421280, 8'h00};
        tv[3]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00,  2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 24'h421280, 8'h00};
        tv[4]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 8'h00,  2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 24'h421280, 8'h00};
        tv[5]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 8'h00,  2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 24'h421280, 8'h00};
        tv[6]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 8'h33,  2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 24'h421280, 8'h33};
        tv[7]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 8'h00,  2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 24'h421280, 8'h33};
        tv[8]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00,  2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 24'h421280, 8'h33};
        tv[9]  = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'h00,  2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 24'hA00500, 8'h33};
        tv[10] = '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 8'h00,  2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 24'hA00500, 8'h33};
        tv[11] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'hA5,  2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 24'hA00500, 8'hA5};
        tv[12] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'h00,  2'b00, 1'b0, 1'b0, 2'b10, 2'b00, 24'hA00500, 8'hA5};
        tv[13] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'h5A,  2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 24'hA00500, 8'hA5};

        rst_n      = 1'b0;
        bus.iSTEP  = 1'b0;
        bus.iREQ   = 2'b00;
        bus.iWR    = 2'b00;
        bus.iWDATA = {24'hA00500, 24'h421280};
        bus.iEND   = 1'b1;
        bus.iACK   = 1'b0;
        bus.iRDATA = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_gnt",   {30'd0, bus.oGNT},  32'd0);
        check("reset_go",    {31'd0, bus.oGO},   32'd0);
        check("reset_wdata", {8'd0, bus.oWDATA}, 32'd0);
        check("reset_rdata", {24'd0, bus.oRDATA}, 32'd0);
        rst_n = 1'b1;

        // Cycle vectors: single write from requester 0, then a read from 1
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.iSTEP  = tv[i].step;
            bus.iREQ   = tv[i].req;
            bus.iWR    = tv[i].wr;
            bus.iEND   = tv[i].iend;
            bus.iACK   = tv[i].ack;
            bus.iRDATA = tv[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_gnt", i),   {30'd0, bus.oGNT},   {30'd0, tv[i].gnt});
            check($sformatf("v%0d_go", i),    {31'd0, bus.oGO},    {31'd0, tv[i].go});
            check($sformatf("v%0d_wr", i),    {31'd0, bus.oWR},    {31'd0, tv[i].owr});
            check($sformatf("v%0d_done", i),  {30'd0, bus.oDONE},  {30'd0, tv[i].done});
            check($sformatf("v%0d_err", i),   {30'd0, bus.oERR},   {30'd0, tv[i].err});
            check($sformatf("v%0d_wdata", i), {8'd0, bus.oWDATA},  {8'd0, tv[i].wdata});
            check($sformatf("v%0d_rdata", i), {24'd0, bus.oRDATA}, {24'd0, tv[i].rdata});
        end

        // Contention: both requesting, strict rotation, pointer back at 0
        bus.iSTEP = 1'b1;
        bus.iWR   = 2'b11;
        bus.iREQ  = 2'b11;
        for (int t = 0; t < 4; t++) begin
            serve(0, gos, g, d, e);
            check($sformatf("cont%0d_gnt", t),  {30'd0, g}, {30'd0, exp_order[t]});
            check($sformatf("cont%0d_done", t), {30'd0, d}, {30'd0, exp_order[t]});
        end
        @(negedge clk);
        check("cont4_gnt", {30'd0, bus.oGNT}, 32'd1);
        bus.iREQ = 2'b01;
        serve(0, gos, g, d, e);
        check("cont4_done", {30'd0, d}, 32'd1);
        bus.iREQ = 2'b00;

        // NACK twice then ACK: three issues and success
        @(negedge clk);
        bus.iREQ = 2'b01;
        serve(2, gos, g, d, e);
        bus.iREQ = 2'b00;
        check("nack2_gos",  gos, 32'd3);
        check("nack2_done", {30'd0, d}, 32'd1);
        check("nack2_err",  {30'd0, e}, 32'd0);

        // NACK four times: retries exhausted, error
        @(negedge clk);
        bus.iACK = 1'b0;
        bus.iREQ = 2'b01;
        serve(4, gos, g, d, e);
        bus.iREQ = 2'b00;
        check("nack4_gos",  gos, 32'd4);
        check("nack4_done", {30'd0, d}, 32'd0);
        check("nack4_err",  {30'd0, e}, 32'd1);

        // Reset while waiting on the engine
        @(negedge clk);
        bus.iACK = 1'b0;
        bus.iEND = 1'b1;
        bus.iREQ = 2'b01;
        @(negedge clk);
        check("rstw_gnt_pre", {30'd0, bus.oGNT}, 32'd1);
        bus.iEND = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstw_go_pre", {31'd0, bus.oGO}, 32'd1);
        rst_n    = 1'b0;
        bus.iREQ = 2'b10;
        #1;
        check("rstw_gnt",   {30'd0, bus.oGNT},  32'd0);
        check("rstw_go",    {31'd0, bus.oGO},   32'd0);
        check("rstw_wr",    {31'd0, bus.oWR},   32'd0);
        check("rstw_wdata", {8'd0, bus.oWDATA}, 32'd0);
        check("rstw_rdata", {24'd0, bus.oRDATA}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rstw_done%0d", c), {30'd0, bus.oDONE}, 32'd0);
            check($sformatf("rstw_err%0d", c),  {30'd0, bus.oERR},  32'd0);
        end
        bus.iEND  = 1'b1;
        bus.iSTEP = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("rstw_nostep_gnt", {30'd0, bus.oGNT}, 32'd0);
        bus.iSTEP = 1'b1;
        @(negedge clk);
        check("rstw_first_gnt", {30'd0, bus.oGNT}, 32'd2);
        serve(0, gos, g, d, e);
        bus.iREQ = 2'b00;
        check("rstw_first_done", {30'd0, d}, 32'd2);

        // Engine stuck busy
        @(negedge clk);
        bus.iACK = 1'b0;
        bus.iEND = 1'b0;
        bus.iREQ = 2'b01;
        go_cnt   = 0;
        err_seen = 2'b00;
        for (int c = 0; c < 40 && err_seen == 2'b00; c++) begin
            @(negedge clk);
            if (bus.oGO) go_cnt++;
            err_seen = bus.oERR;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        bus.iREQ = 2'b00;
        check("tmo_go_steps", go_cnt, 32'd8);
        check("tmo_err",      {30'd0, err_seen}, 32'd1);
        check("tmo_go_low",   {31'd0, bus.oGO}, 32'd0);
`else
        check("notmo_err",    {30'd0, err_seen}, 32'd0);
        check("notmo_go",     {31'd0, bus.oGO}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
